// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester handshakes (instruction fetch, data) and the
//   single memory port that the arbiter shares between them.
//   Modports:
//     master : the arbiter view (samples requests and memory completion,
//              drives acks, read data and the memory request/qualifiers)
//     slave  : the environment view (requesters plus memory)
//   Signals:
//     inst_req/inst_addr -> inst_ack/inst_rdata        fetch handshake
//     data_req/we/addr/wdata/byte_en -> data_ack/rdata load/store handshake
//     mem_req/we/addr/wdata/byte_en -> mem_rdata/ready memory port
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic              inst_ack;
   logic [DATA_W-1:0] inst_rdata;

   logic              data_req;
   logic              data_we;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic [3:0]        data_byte_en;
   logic              data_ack;
   logic [DATA_W-1:0] data_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_byte_en;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      input  inst_req, inst_addr,
      input  data_req, data_we, data_addr, data_wdata, data_byte_en,
      input  mem_rdata, mem_ready,
      output inst_ack, inst_rdata, data_ack, data_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en
   );

   modport slave (
      output inst_req, inst_addr,
      output data_req, data_we, data_addr, data_wdata, data_byte_en,
      output mem_rdata, mem_ready,
      input  inst_ack, inst_rdata, data_ack, data_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch requester
//   and the data requester. Data has priority, but after DATA_STREAK_MAX
//   consecutive data grants with a fetch waiting, the fetch is forced in.
//   A transaction whose memory never completes is aborted after TIMEOUT
//   wait cycles and acknowledged with bus_err.
//   Ports:
//     clk     : rising-edge clock
//     reset   : synchronous, active-low reset
//     bus     : requester + memory handshakes (mem_port_arbiter_if.master)
//     bus_err : one-cycle pulse alongside an ack produced by a timeout
//     busy    : 1 whenever the arbiter is not idle
module mem_port_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int DATA_STREAK_MAX = 4,
   parameter int TIMEOUT         = 255
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.master  bus,
   output logic                bus_err,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ACK} state_t;

   localparam logic [3:0] STREAK_LIM  = 4'(DATA_STREAK_MAX);
   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

   state_t     state;
   state_t     state_next;
   logic [3:0] streak;
   logic [7:0] wait_cnt;
   logic [7:0] wait_inc;
   logic       grant_d;
   logic       grant_i;
   logic       done_ok;
   logic       done_to;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign wait_inc = sat_inc8(wait_cnt);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      done_ok    = 1'b0;
      done_to    = 1'b0;
      case (state)
         IDLE: begin
            // A waiting fetch only overrides data once the streak is used up.
            if (bus.data_req && ((streak < STREAK_LIM) || !bus.inst_req)) begin
               grant_d    = 1'b1;
               state_next = BUSY_D;
            end else if (bus.inst_req) begin
               grant_i    = 1'b1;
               state_next = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            // Completion on the last allowed wait cycle still counts as success.
            if (bus.mem_ready) begin
               done_ok    = 1'b1;
               state_next = ACK;
            end else if (wait_inc == TIMEOUT_LIM) begin
               done_to    = 1'b1;
               state_next = ACK;
            end
         end
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.mem_req     <= 1'b0;
         bus.mem_we      <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_wdata   <= '0;
         bus.mem_byte_en <= 4'h0;
         bus.inst_ack    <= 1'b0;
         bus.data_ack    <= 1'b0;
         bus.inst_rdata  <= '0;
         bus.data_rdata  <= '0;
         bus_err         <= 1'b0;
         streak          <= 4'd0;
         wait_cnt        <= 8'd0;
      end else begin
         bus.inst_ack <= 1'b0;
         bus.data_ack <= 1'b0;
         bus_err      <= 1'b0;

         // grant: capture the winner's qualifiers onto the memory port
         if (grant_d) begin
            bus.mem_req     <= 1'b1;
            bus.mem_we      <= bus.data_we;
            bus.mem_addr    <= bus.data_addr;
            bus.mem_wdata   <= bus.data_wdata;
            bus.mem_byte_en <= bus.data_byte_en;
            streak          <= bus.inst_req ? sat_inc4(streak) : 4'd0;
            wait_cnt        <= 8'd0;
         end else if (grant_i) begin
            bus.mem_req     <= 1'b1;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= bus.inst_addr;
            bus.mem_byte_en <= 4'hF;
            streak          <= 4'd0;
            wait_cnt        <= 8'd0;
         end

         // memory access: count wait cycles, finish on ready or timeout
         if (state == BUSY_I || state == BUSY_D) begin
            wait_cnt <= wait_inc;
            if (done_ok || done_to) begin
               bus.mem_req <= 1'b0;
               bus_err     <= done_to;
               if (state == BUSY_I) begin
                  bus.inst_ack   <= 1'b1;
                  bus.inst_rdata <= done_ok ? bus.mem_rdata : '0;
               end else begin
                  bus.data_ack   <= 1'b1;
                  bus.data_rdata <= done_ok ? bus.mem_rdata : '0;
               end
            end
         end

         if (state == ACK) wait_cnt <= 8'd0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives both requesters and a memory with variable wait states, and
//   predicts grant order, memory-port contents, ack timing, bus_err and read
//   data from a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

   localparam int SMAX = 4;
   localparam int TO   = 8;

   logic clk = 1'b0;
   logic reset;
   logic bus_err;
   logic busy;

   int total = 0;
   int bad   = 0;

   // model state
   int          streak;
   logic [31:0] exp_ird;
   logic [31:0] exp_drd;
   bit          drd_known;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .DATA_STREAK_MAX(SMAX), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .bus_err(bus_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic new_inst();
      bus.inst_req  = 1'b1;
      bus.inst_addr = $urandom & 32'hFFFF_FFFC;
   endtask

   task automatic new_data();
      bus.data_req     = 1'b1;
      bus.data_we      = 1'($urandom);
      bus.data_addr    = $urandom;
      bus.data_wdata   = $urandom;
      bus.data_byte_en = 4'($urandom);
   endtask

   // From an idle cycle with requests presented: one full transaction,
   // ending in the ack cycle. w = memory wait states before mem_ready.
   task automatic run_txn(input int w, input logic [31:0] rd, output bit was_data);
      bit          win_d;
      bit          tmo;
      logic [31:0] ea;
      logic [31:0] ewd;
      logic        ewe;
      logic [3:0]  ebe;
      int          hold;
      win_d = bus.data_req && ((streak < SMAX) || !bus.inst_req);
      ewd   = bus.data_wdata;
      if (win_d) begin
         ea  = bus.data_addr;
         ewe = bus.data_we;
         ebe = bus.data_byte_en;
         streak = bus.inst_req ? streak + 1 : 0;
      end else begin
         ea  = bus.inst_addr;
         ewe = 1'b0;
         ebe = 4'hF;
         streak = 0;
      end
      tmo  = (w >= TO);
      hold = tmo ? TO : w + 1;
      step();
      bus.mem_ready = 1'b0;
      for (int c = 0; c < hold; c++) begin
         check_eq("busy_mem_req", 32'(bus.mem_req), 32'd1);
         check_eq("busy_mem_addr", bus.mem_addr, ea);
         check_eq("busy_mem_we", 32'(bus.mem_we), 32'(ewe));
         check_eq("busy_mem_be", 32'(bus.mem_byte_en), 32'(ebe));
         if (ewe) check_eq("busy_mem_wdata", bus.mem_wdata, ewd);
         check_eq("busy_no_ack", 32'({bus.inst_ack, bus.data_ack}), 32'd0);
         check_eq("busy_flag", 32'(busy), 32'd1);
         bus.mem_ready = (c == w);
         bus.mem_rdata = (c == w) ? rd : $urandom;
         step();
      end
      bus.mem_ready = 1'b0;
      if (win_d) begin
         if (tmo)       exp_drd = 32'd0;
         else if (!ewe) exp_drd = rd;
         drd_known = tmo || !ewe;
      end else begin
         exp_ird = tmo ? 32'd0 : rd;
      end
      check_eq("ack_owner", 32'({bus.inst_ack, bus.data_ack}), win_d ? 32'd1 : 32'd2);
      check_eq("ack_bus_err", 32'(bus_err), 32'(tmo));
      check_eq("ack_mem_req", 32'(bus.mem_req), 32'd0);
      check_eq("ack_busy", 32'(busy), 32'd1);
      check_eq("inst_rdata", bus.inst_rdata, exp_ird);
      if (drd_known) check_eq("data_rdata", bus.data_rdata, exp_drd);
      was_data = win_d;
   endtask

   // ack cycle -> idle cycle
   task automatic idle_step();
      step();
      check_eq("idle_acks", 32'({bus.inst_ack, bus.data_ack}), 32'd0);
      check_eq("idle_bus_err", 32'(bus_err), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_mem_req", 32'(bus.mem_req), 32'd0);
   endtask

   initial begin
      bit wd;
      int w;
      bit exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

      reset = 1'b0;
      bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_1000;
      bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h0000_2000;
      bus.data_wdata = 32'h0; bus.data_byte_en = 4'h0;
      bus.mem_rdata = 32'h0; bus.mem_ready = 1'b0;

      // reset held with both requests pending
      repeat (3) step();
      check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
      check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check_eq("rst_mem_be", 32'(bus.mem_byte_en), 32'd0);
      check_eq("rst_acks", 32'({bus.inst_ack, bus.data_ack}), 32'd0);
      check_eq("rst_bus_err", 32'(bus_err), 32'd0);
      check_eq("rst_inst_rdata", bus.inst_rdata, 32'd0);
      check_eq("rst_data_rdata", bus.data_rdata, 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      streak = 0; exp_ird = 32'd0; exp_drd = 32'd0; drd_known = 1'b1;
      reset = 1'b1;

      // both requesters continuously busy: D,D,D,D,I repeating
      for (int i = 0; i < 10; i++) begin
         run_txn(i % 3, $urandom, wd);
         check_eq("grant_order", 32'(wd), 32'(exp_order[i]));
         if (wd) new_data(); else new_inst();
         if (i == 9) begin
            bus.data_req = 1'b0;
            bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_0040;
         end
         idle_step();
      end

      // fetch only, zero wait states
      run_txn(0, 32'h2008_0005, wd);
      bus.inst_req = 1'b0;
      bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 32'h0000_0100;
      bus.data_wdata = 32'hDEAD_BEEF; bus.data_byte_en = 4'b0011;
      idle_step();

      // store with three wait states
      run_txn(3, $urandom, wd);
      bus.data_we = 1'b0; bus.data_addr = 32'h0000_0200;
      idle_step();

      // memory never answers: timeout abort
      run_txn(1000, $urandom, wd);
      bus.data_req = 1'b0;
      bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_0080;
      idle_step();

      // reset in the second cycle of a fetch
      step();
      check_eq("rstmid_req_c1", 32'(bus.mem_req), 32'd1);
      step();
      check_eq("rstmid_req_c2", 32'(bus.mem_req), 32'd1);
      reset = 1'b0;
      step();
      check_eq("rstmid_mem_req", 32'(bus.mem_req), 32'd0);
      check_eq("rstmid_busy", 32'(busy), 32'd0);
      check_eq("rstmid_acks", 32'({bus.inst_ack, bus.data_ack}), 32'd0);
      reset = 1'b1;
      bus.inst_req = 1'b0;
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
      streak = 0; exp_ird = 32'd0; exp_drd = 32'd0; drd_known = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("late_ready_acks", 32'({bus.inst_ack, bus.data_ack}), 32'd0);
         check_eq("late_ready_mem_req", 32'(bus.mem_req), 32'd0);
         check_eq("late_ready_busy", 32'(busy), 32'd0);
         check_eq("late_ready_inst_rdata", bus.inst_rdata, 32'd0);
      end
      bus.mem_ready = 1'b0;

      // randomized traffic
      for (int t = 0; t < 200; t++) begin
         if (!bus.inst_req && !bus.data_req) begin
            if ($urandom_range(0, 1) == 0) new_inst(); else new_data();
         end
         w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 3))
                                         : int'($urandom_range(0, 3));
         run_txn(w, $urandom, wd);
         if (wd) begin
            if ($urandom_range(0, 9) < 7) new_data(); else bus.data_req = 1'b0;
         end else begin
            if ($urandom_range(0, 9) < 7) new_inst(); else bus.inst_req = 1'b0;
         end
         if (!bus.inst_req && $urandom_range(0, 3) == 0) new_inst();
         bus.mem_ready = 1'($urandom);
         bus.mem_rdata = $urandom;
         idle_step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
